// File: rtl/cic_decim_multi.sv
// cic_decim_multi: multi-channel CIC decimator for 1-bit sigma-delta bitstreams
//   clk        system clock
//   rst        asynchronous active-low reset
//   Bit_in     one bitstream bit per channel (bit c = channel c)
//   in_valid   one-clk strobe marking a new sample on all channels
//   dec_log2   decimation select, R = 2^dec_log2, legal 0..RMAX_LOG2
//   Filter_out channel c at [c*OW +: OW], signed, gain R^N
//   rdy        one-clk pulse when Filter_out holds a new sample
//   settled    high once the post-reset / post-reconfiguration fill is done
//   ratio_err  sticky flag for an out-of-range dec_log2
module cic_decim_multi #(
    parameter int CH        = 2,
    parameter int N         = 5,
    parameter int RMAX_LOG2 = 6,
    parameter int OW        = 2 + N * RMAX_LOG2,
    parameter int DISCARD   = N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    Bit_in,
    input  logic             in_valid,
    input  logic [3:0]       dec_log2,
    output logic [CH*OW-1:0] Filter_out,
    output logic             rdy,
    output logic             settled,
    output logic             ratio_err
);
    localparam int DW = $clog2(DISCARD + 1);
    typedef enum logic [1:0] {FILL, RUN, RECONF} state_t;
    state_t                 state;
    logic                   started;
    logic [3:0]             r_log2, pend;
    logic [RMAX_LOG2-1:0]   cnt, cnt_max;
    logic [DW-1:0]          disc;
    // v[0] is the decimation strobe; v[k] marks comb stage k's output as fresh
    logic [N:0]             v;
    logic [OW-1:0]          integ [CH][N];
    logic [OW-1:0]          comb  [CH][N];
    logic [OW-1:0]          dly   [CH][N];
    logic                   wrap, legal, change;
    assign cnt_max = RMAX_LOG2'((32'd1 << r_log2) - 32'd1);
    assign wrap    = in_valid && cnt == cnt_max;
    assign legal   = dec_log2 <= 4'(RMAX_LOG2);
    assign change  = wrap && legal && dec_log2 != r_log2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FILL;
            started    <= 1'b0;
            r_log2     <= '0;
            pend       <= '0;
            cnt        <= '0;
            disc       <= '0;
            v          <= '0;
            Filter_out <= '0;
            rdy        <= 1'b0;
            settled    <= 1'b0;
            ratio_err  <= 1'b0;
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < N; k++) begin
                    integ[c][k] <= '0;
                    comb[c][k]  <= '0;
                    dly[c][k]   <= '0;
                end
        end else if (state == RECONF) begin
            state   <= FILL;
            r_log2  <= pend;
            cnt     <= '0;
            disc    <= '0;
            v       <= '0;
            rdy     <= 1'b0;
            settled <= 1'b0;
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < N; k++) begin
                    integ[c][k] <= '0;
                    comb[c][k]  <= '0;
                    dly[c][k]   <= '0;
                end
        end else begin
            rdy <= 1'b0;
            if (!started) begin
                started <= 1'b1;
                if (legal) r_log2 <= dec_log2;
                else ratio_err <= 1'b1;
            end
            if (wrap && !legal) ratio_err <= 1'b1;
            // a block that triggers reconfiguration never reaches the combs
            v <= {v[N-1:0], wrap && !change};
            if (in_valid) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
                for (int c = 0; c < CH; c++) begin
                    integ[c][0] <= integ[c][0] + {{(OW-1){~Bit_in[c]}}, 1'b1};
                    for (int k = 1; k < N; k++)
                        integ[c][k] <= integ[c][k] + integ[c][k-1];
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (v[0]) begin
                    comb[c][0] <= integ[c][N-1] - dly[c][0];
                    dly[c][0]  <= integ[c][N-1];
                end
                for (int k = 1; k < N; k++)
                    if (v[k]) begin
                        comb[c][k] <= comb[c][k-1] - dly[c][k];
                        dly[c][k]  <= comb[c][k-1];
                    end
            end
            if (v[N]) begin
                if (state == RUN) begin
                    rdy <= 1'b1;
                    for (int c = 0; c < CH; c++) Filter_out[c*OW +: OW] <= comb[c][N-1];
                end else if (disc == DW'(DISCARD - 1)) begin
                    state   <= RUN;
                    settled <= 1'b1;
                    disc    <= '0;
                end else
                    disc <= disc + 1'b1;
            end
            if (change) begin
                state <= RECONF;
                pend  <= dec_log2;
            end
        end
    end
endmodule
